// File: rtl/rx_frame_store.sv
// rtl/rx_frame_store.sv - store-and-forward receive frame buffer with FCS strip and commit/rollback
module rx_frame_store #(
    parameter int ADDR_W    = 11,
    parameter int LEN_AW    = 3,
    parameter int STRIP     = 4,
    parameter int AF_THRESH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic        stat_valid,
    input  logic        stat_ok,
    input  logic        rd_byte,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        byte_empty,
    input  logic        rd_len,
    output logic [15:0] frm_len,
    output logic        len_empty,
    output logic        fifo_full,
    output logic [15:0] drop_cnt
);
    localparam int PW = ADDR_W + 1;
    localparam int LW = LEN_AW + 1;
    localparam logic [PW-1:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PW-1:0] STRIP_P   = PW'(STRIP);
    localparam logic [PW-1:0] AF_P      = PW'(AF_THRESH);
    localparam logic [PW-1:0] ONE_P     = PW'(1);
    localparam logic [15:0]   STRIP16   = 16'(STRIP);
    localparam logic [LW-1:0] LEN_DEPTH = {1'b1, {LEN_AW{1'b0}}};
    localparam logic [LW-1:0] LONE      = LW'(1);

    typedef enum logic [1:0] {IDLE, RECV, DROP, WAIT_STAT} state_t;
    state_t state;

    logic [7:0]    mem     [1 << ADDR_W];
    logic [15:0]   len_mem [1 << LEN_AW];
    logic [PW-1:0] wr_ptr, cm_ptr, st_ptr, rd_ptr;
    logic [LW-1:0] len_wp, len_rp;
    logic [15:0]   cnt;
    logic          drop_flag;

    logic          is_rx, wr_en, ovf, decide, commit, rollback, drop_inc;
    logic          rd_pop, len_pop, len_full;
    logic [15:0]   cnt_upd, dec_cnt, commit_len;
    logic [PW-1:0] free, free_nxt, st_cur, commit_end, wr_nxt, cm_nxt, rd_nxt;
    logic [LW-1:0] len_wp_nxt, len_rp_nxt;

    always_comb begin
        is_rx      = (state == IDLE) || (state == RECV);
        free       = DEPTH - (wr_ptr - rd_ptr);
        wr_en      = in_valid && is_rx && (free != '0);
        ovf        = in_valid && is_rx && (free == '0);
        cnt_upd    = (state == IDLE) ? 16'd1 : ((cnt == 16'hFFFF) ? cnt : cnt + 16'd1);
        st_cur     = (state == IDLE) ? wr_ptr : st_ptr;
        // status coincident with the last byte is judged on the count including that byte
        decide     = (wr_en && in_last && stat_valid) ||
                     ((state == WAIT_STAT) && stat_valid && !in_valid);
        dec_cnt    = (state == WAIT_STAT) ? cnt : cnt_upd;
        len_full   = (len_wp - len_rp) == LEN_DEPTH;
        commit     = decide && stat_ok && (dec_cnt > STRIP16) && !len_full;
        rollback   = (decide && !commit) || (ovf && in_last) ||
                     ((state == DROP) && in_valid && in_last) ||
                     ((state == WAIT_STAT) && in_valid);
        drop_inc   = rollback && !((state == DROP) && drop_flag);
        commit_end = st_cur + dec_cnt[PW-1:0] - STRIP_P;
        commit_len = dec_cnt - STRIP16;

        wr_nxt = wr_ptr;
        if (commit)
            wr_nxt = commit_end;
        else if (rollback)
            wr_nxt = st_cur;
        else if (wr_en)
            wr_nxt = wr_ptr + ONE_P;
        cm_nxt     = commit ? commit_end : cm_ptr;
        rd_pop     = rd_byte && (cm_ptr != rd_ptr);
        rd_nxt     = rd_pop ? rd_ptr + ONE_P : rd_ptr;
        free_nxt   = DEPTH - (wr_nxt - rd_nxt);
        len_pop    = rd_len && (len_wp != len_rp);
        len_wp_nxt = commit ? len_wp + LONE : len_wp;
        len_rp_nxt = len_pop ? len_rp + LONE : len_rp;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[ADDR_W-1:0]] <= in_data;
        if (commit)
            len_mem[len_wp[LEN_AW-1:0]] <= commit_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            cm_ptr     <= '0;
            st_ptr     <= '0;
            rd_ptr     <= '0;
            len_wp     <= '0;
            len_rp     <= '0;
            cnt        <= '0;
            drop_flag  <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            byte_empty <= 1'b1;
            len_empty  <= 1'b1;
            frm_len    <= '0;
            fifo_full  <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            wr_ptr     <= wr_nxt;
            cm_ptr     <= cm_nxt;
            rd_ptr     <= rd_nxt;
            len_wp     <= len_wp_nxt;
            len_rp     <= len_rp_nxt;
            out_valid  <= rd_pop;
            if (rd_pop)
                out_data <= mem[rd_ptr[ADDR_W-1:0]];
            byte_empty <= (cm_nxt == rd_nxt);
            len_empty  <= (len_wp_nxt == len_rp_nxt);
            fifo_full  <= (free_nxt < AF_P);
            // show-ahead head: a push into an empty queue bypasses the length memory
            if (len_pop || (commit && (len_wp == len_rp)))
                frm_len <= (len_rp_nxt != len_wp) ? len_mem[len_rp_nxt[LEN_AW-1:0]]
                                                  : (commit ? commit_len : 16'd0);
            if (drop_inc && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;

            case (state)
                IDLE, RECV: begin
                    if (in_valid) begin
                        if (state == IDLE)
                            st_ptr <= wr_ptr;
                        cnt <= cnt_upd;
                        if (ovf) begin
                            drop_flag <= 1'b0;
                            state     <= in_last ? IDLE : DROP;
                        end else if (in_last) begin
                            state <= stat_valid ? IDLE : WAIT_STAT;
                        end else begin
                            state <= RECV;
                        end
                    end
                end
                DROP: begin
                    if (in_valid && in_last)
                        state <= IDLE;
                end
                WAIT_STAT: begin
                    // new bytes before status: pending frame is dropped and counted once
                    if (in_valid) begin
                        drop_flag <= 1'b1;
                        state     <= in_last ? IDLE : DROP;
                    end else if (stat_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/rx_frame_store.md
Name: rx_frame_store

Overview:
- Store-and-forward receive buffer between the MAC receive byte stream and tx_control, on the rx_mac_clk domain.
- Replaces the separate byte FIFO and length FIFO pair with one block.
- Writes each frame speculatively and strips the trailing FCS.
- When the MAC status arrives, the frame is either committed (bytes become readable and its length is queued) or rolled back, so tx_control only ever sees complete, good frames.

Parameters:
- ADDR_W, 11, byte-buffer address width (depth 2^ADDR_W = 2048 bytes).
- LEN_AW, 3, length-queue address width (8 committed frames).
- STRIP, 4, trailing bytes removed per frame (FCS).
- AF_THRESH, 64, free-byte level below which fifo_full asserts.

Ports:
- clk  in  1  single clock (rx_mac_clk in the top level).
- rst  in  1  synchronous reset, active-high.
- in_data  in  8  receive byte from MAC (rx_mac_data).
- in_valid  in  1  byte strobe (rx_mac_valid).
- in_last  in  1  final byte of frame, qualified by in_valid (rx_mac_last).
- stat_valid  in  1  frame status strobe (rx_stat_valid).
- stat_ok  in  1  frame good, sampled with stat_valid (rx_stat_vector[0]).
- rd_byte  in  1  pop one committed byte (tx_control nextByte).
- out_data  out  8  popped byte.
- out_valid  out  1  out_data valid, one-cycle pulse.
- byte_empty  out  1  no committed bytes.
- rd_len  in  1  pop one frame length (tx_control nextLen).
- frm_len  out  16  head of length queue (show-ahead).
- len_empty  out  1  length queue empty.
- fifo_full  out  1  free bytes < AF_THRESH (to rx_control pause logic).
- drop_cnt  out  16  dropped-frame counter, saturating at 16'hFFFF.

Behaviour:
- Reset values: out_data=0, out_valid=0, byte_empty=1, len_empty=1, frm_len=0, fifo_full=0, drop_cnt=0. All pointers=0, state=IDLE.
- Reset mid-frame discards the partial frame. The first in_valid after reset starts a new frame.
- Pointers are (ADDR_W+1) bits: wr_ptr (speculative), cm_ptr (committed end), st_ptr (frame start), rd_ptr. Free space = 2^ADDR_W - (wr_ptr - rd_ptr).
- State IDLE: in_valid writes the byte, st_ptr<=wr_ptr, cnt<=1, go to RECV. If in_last is also set, go to WAIT_STAT.
- State RECV: each in_valid writes and increments cnt (16-bit, saturating). in_last -> WAIT_STAT.
- Overflow: in_valid with free space = 0 does not write. Go to DROP, or straight to rollback if in_last is set on that byte.
- State DROP: ignore bytes until in_valid&in_last, then roll back.
- State WAIT_STAT: on stat_valid, commit if stat_ok=1, cnt>STRIP, and the length queue is not full. Otherwise roll back.
  - stat_valid arriving in the same cycle as the last byte is accepted. The decision then uses the updated cnt.
- Commit: cm_ptr<=st_ptr+cnt-STRIP, wr_ptr<=cm_ptr new value (FCS bytes reclaimed), push cnt-STRIP into the length queue, go to IDLE.
- Rollback: wr_ptr<=st_ptr, drop_cnt+1, go to IDLE.
- in_valid during WAIT_STAT is a protocol error: roll back the pending frame, then enter DROP for the new bytes. drop_cnt counts this as 1.
- stat_valid outside WAIT_STAT (and not coincident with the last byte) is ignored.
- Read side:
  - rd_byte with cm_ptr!=rd_ptr: out_data=mem[rd_ptr] and out_valid=1 on the next cycle, rd_ptr+1.
  - rd_byte while byte_empty is ignored, and out_valid stays 0.
  - byte_empty and len_empty are registered and reflect a commit one cycle after it.
  - Commit and pop in the same cycle are both honoured.
- Length queue: rd_len while len_empty is ignored. frm_len updates the cycle after a pop or a push-to-empty.
- fifo_full is registered from the free space after that cycle's write and read activity.
- Pointer wrap is handled by the extra MSB. A frame may straddle the buffer end.

Test Plan:
- 64-byte frame (bytes 0x00..0x3F, last on 0x3F), stat_ok=1 two cycles later -> frm_len=60, len_empty=0. 60 rd_byte pops return 0x00..0x3B with out_valid one cycle after each. byte_empty=1 afterwards.
- Same frame with stat_ok=0 -> drop_cnt=1, len_empty=1, byte_empty=1, wr_ptr back at its start value. A following good 64-byte frame reads from the same addresses.
- 2100-byte frame into empty buffer with no reads -> DROP, drop_cnt=1, nothing committed. A following 100-byte good frame is committed with frm_len=96.
- Frame 1 committed; frame 2 in_valid arrives during WAIT_STAT -> frame 2 dropped, frame 1 intact, drop_cnt=1.
- 3-byte frame with stat_ok=1 -> dropped (cnt≤STRIP). stat_valid in the same cycle as in_last on a 10-byte frame -> committed, frm_len=6.
- Reset asserted mid-frame, then a 64-byte good frame -> only frm_len=60 queued. Prefill to 1990 unread bytes -> fifo_full=1. Pop to 1984 bytes -> fifo_full=0.
